// File: rtl/scr1_dp_memory_pipe.sv
// Dual-port synchronous RAM: port A read-only, port B read/write with byte enables.
// A post-reset sweep fills every word with SCR1_INIT_VAL before either port is serviced.
module scr1_dp_memory_pipe #(
    parameter int                    SCR1_WIDTH    = 32,
    parameter int                    SCR1_SIZE     = 65536,
    parameter int                    SCR1_NBYTES   = SCR1_WIDTH / 8,
    parameter int                    SCR1_RD_PIPE  = 0,
    parameter int                    SCR1_BYPASS   = 1,
    parameter logic [SCR1_WIDTH-1:0] SCR1_INIT_VAL = '0,
    localparam int                   DEPTH         = SCR1_SIZE / SCR1_NBYTES,
    localparam int                   AW            = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   init_done,
    input  logic                   rena,
    input  logic [AW-1:0]          addra,
    output logic [SCR1_WIDTH-1:0]  qa,
    output logic                   qa_vld,
    input  logic                   renb,
    input  logic                   wenb,
    input  logic [SCR1_NBYTES-1:0] webb,
    input  logic [AW-1:0]          addrb,
    input  logic [SCR1_WIDTH-1:0]  datab,
    output logic [SCR1_WIDTH-1:0]  qb,
    output logic                   qb_vld
);

    localparam logic [0:0]    ST_INIT  = 1'b0;
    localparam logic [0:0]    ST_READY = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  ready;
    logic [SCR1_WIDTH-1:0] mem [DEPTH];

    logic [SCR1_NBYTES-1:0] wr_be;
    logic [AW-1:0]          wr_addr;
    logic [SCR1_WIDTH-1:0]  wr_data;
    logic [SCR1_WIDTH-1:0]  rda_word;
    logic                   rd_a_req, rd_b_req;

    logic                  a1_vld_q, b1_vld_q;
    logic [SCR1_WIDTH-1:0] a1_data_q, b1_data_q;

    // init_done is the externally visible FSM state.
    assign ready     = (state_q == ST_READY);
    assign init_done = ready;
    assign rd_a_req  = ready & rena;
    assign rd_b_req  = ready & renb;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The single write port is shared between the sweep and port B.
    always_comb begin
        if (!ready) begin
            wr_be   = '1;
            wr_addr = cnt_q;
            wr_data = SCR1_INIT_VAL;
        end else begin
            wr_be   = wenb ? webb : '0;
            wr_addr = addrb;
            wr_data = datab;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SCR1_NBYTES; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rda_word = mem[addra];
        if ((SCR1_BYPASS != 0) && ready && wenb && (addrb == addra)) begin
            for (int i = 0; i < SCR1_NBYTES; i++) begin
                if (webb[i]) begin
                    rda_word[8*i +: 8] = datab[8*i +: 8];
                end
            end
        end
    end

    // Port B reads the array before this edge's write lands (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_vld_q  <= 1'b0;
            a1_data_q <= '0;
            b1_vld_q  <= 1'b0;
            b1_data_q <= '0;
        end else begin
            a1_vld_q <= rd_a_req;
            b1_vld_q <= rd_b_req;
            if (rd_a_req) begin
                a1_data_q <= rda_word;
            end
            if (rd_b_req) begin
                b1_data_q <= mem[addrb];
            end
        end
    end

    generate
        if (SCR1_RD_PIPE != 0) begin : g_pipe
            logic                  a2_vld_q, b2_vld_q;
            logic [SCR1_WIDTH-1:0] a2_data_q, b2_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a2_vld_q  <= 1'b0;
                    a2_data_q <= '0;
                    b2_vld_q  <= 1'b0;
                    b2_data_q <= '0;
                end else begin
                    a2_vld_q <= a1_vld_q;
                    b2_vld_q <= b1_vld_q;
                    if (a1_vld_q) begin
                        a2_data_q <= a1_data_q;
                    end
                    if (b1_vld_q) begin
                        b2_data_q <= b1_data_q;
                    end
                end
            end

            assign qa     = a2_data_q;
            assign qa_vld = a2_vld_q;
            assign qb     = b2_data_q;
            assign qb_vld = b2_vld_q;
        end else begin : g_nopipe
            assign qa     = a1_data_q;
            assign qa_vld = a1_vld_q;
            assign qb     = b1_data_q;
            assign qb_vld = b1_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_scr1_dp_memory_pipe.sv
// Directed bench: three RAM configurations share one stimulus stream and are
// checked every cycle against hand-computed expectations.
module tb_scr1_dp_memory_pipe;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rena = 1'b0, renb = 1'b0, wenb = 1'b0;
    logic [3:0]  addra = '0, addrb = '0, webb = '0;
    logic [31:0] datab = '0;

    logic        done0, done1, done2;
    logic        qav0, qav1, qav2, qbv0, qbv1, qbv2;
    logic [31:0] qa0, qa1, qa2, qb0, qb1, qb2;

    always #5 clk = ~clk;

    // inst 0: no pipe, bypass; inst 1: pipe, bypass; inst 2: no pipe, no bypass
    scr1_dp_memory_pipe #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .SCR1_RD_PIPE(0),
                          .SCR1_BYPASS(1), .SCR1_INIT_VAL(IV)) dut0 (
        .clk(clk), .rst_n(rst_n), .init_done(done0),
        .rena(rena), .addra(addra), .qa(qa0), .qa_vld(qav0),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
        .qb(qb0), .qb_vld(qbv0));

    scr1_dp_memory_pipe #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .SCR1_RD_PIPE(1),
                          .SCR1_BYPASS(1), .SCR1_INIT_VAL(IV)) dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(done1),
        .rena(rena), .addra(addra), .qa(qa1), .qa_vld(qav1),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
        .qb(qb1), .qb_vld(qbv1));

    scr1_dp_memory_pipe #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .SCR1_RD_PIPE(0),
                          .SCR1_BYPASS(0), .SCR1_INIT_VAL(IV)) dut2 (
        .clk(clk), .rst_n(rst_n), .init_done(done2),
        .rena(rena), .addra(addra), .qa(qa2), .qa_vld(qav2),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
        .qb(qb2), .qb_vld(qbv2));

    typedef struct {
        int          port;
        int          due;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_d[6];
    int          cyc = 0;
    int          sweep_left = 16;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int inst);
        return (inst == 1) ? 2 : 1;
    endfunction

    // Per-cycle scoreboard: vld pulses only when due, data holds between pulses.
    task automatic monitor();
        logic [31:0] obs_d[6];
        logic        obs_v[6];
        logic        obs_done[3];
        logic        exp_v;
        logic        exp_done;
        obs_d = '{qa0, qb0, qa1, qb1, qa2, qb2};
        obs_v = '{qav0, qbv0, qav1, qbv1, qav2, qbv2};
        obs_done = '{done0, done1, done2};
        exp_done = rst_n && (sweep_left == 0);
        for (int p = 0; p < 6; p++) begin
            exp_v = 1'b0;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].port == p && exp_q[k].due == cyc) begin
                    exp_v = 1'b1;
                    last_d[p] = exp_q[k].d;
                    exp_q.delete(k);
                    break;
                end
            end
            check($sformatf("vld p%0d c%0d", p, cyc), 32'(obs_v[p]), 32'(exp_v));
            check($sformatf("data p%0d c%0d", p, cyc), obs_d[p], last_d[p]);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("init_done i%0d c%0d", i, cyc), 32'(obs_done[i]), 32'(exp_done));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && sweep_left > 0) sweep_left--;
        monitor();
    endtask

    task automatic issue(input logic ra, input logic [3:0] aa,
                         input logic rb, input logic wb, input logic [3:0] be,
                         input logic [3:0] ab, input logic [31:0] db,
                         input logic [31:0] ea_byp, input logic [31:0] ea_old,
                         input logic [31:0] eb);
        exp_t e;
        rena = ra; addra = aa; renb = rb; wenb = wb; webb = be; addrb = ab; datab = db;
        if (rst_n && sweep_left == 0) begin
            for (int i = 0; i < 3; i++) begin
                if (ra) begin
                    e.port = 2 * i; e.due = cyc + lat_of(i);
                    e.d = (i == 2) ? ea_old : ea_byp;
                    exp_q.push_back(e);
                end
                if (rb) begin
                    e.port = 2 * i + 1; e.due = cyc + lat_of(i); e.d = eb;
                    exp_q.push_back(e);
                end
            end
        end
        step();
    endtask

    task automatic idle(input int n);
        rena = 1'b0; renb = 1'b0; wenb = 1'b0; webb = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        for (int p = 0; p < 6; p++) last_d[p] = '0;
        sweep_left = 16;
    endtask

    function automatic logic [31:0] word_after_writes(input int a);
        case (a)
            2:       return 32'h0BADF00D;
            3:       return 32'hCA22F044;
            5:       return 32'hDEADBEEF;
            7:       return 32'h12345678;
            default: return IV;
        endcase
    endfunction

    initial begin
        do_reset();
        idle(3);
        rst_n = 1'b1;
        // Sweep: reads ignored, port B writes to word 9 must not land.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'(i), 1'b1, 1'b1, 4'hF, 4'd9, 32'h0, '0, '0, '0);
        end
        idle(2);

        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'(i), 1'b1, 1'b0, 4'h0, 4'(i), '0, IV, IV, IV);
        end
        idle(3);

        // Byte-lane write then readback on both ports.
        issue(1'b0, 4'd0, 1'b0, 1'b1, 4'b0101, 4'd3, 32'h11223344, '0, '0, '0);
        issue(1'b1, 4'd3, 1'b1, 1'b0, 4'b0000, 4'd3, '0, 32'hA522A544, 32'hA522A544, 32'hA522A544);
        idle(3);

        // webb=0 write leaves the word alone.
        issue(1'b0, 4'd0, 1'b0, 1'b1, 4'b0000, 4'd9, 32'hFFFFFFFF, '0, '0, '0);
        issue(1'b1, 4'd9, 1'b1, 1'b0, 4'b0000, 4'd9, '0, IV, IV, IV);
        idle(3);

        // Same-address collisions: full and partial lanes.
        issue(1'b1, 4'd5, 1'b1, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, IV, IV);
        idle(3);
        issue(1'b1, 4'd5, 1'b1, 1'b0, 4'h0, 4'd5, '0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        idle(3);
        issue(1'b1, 4'd3, 1'b1, 1'b1, 4'b1010, 4'd3, 32'hCAFEF00D,
              32'hCA22F044, 32'hA522A544, 32'hA522A544);
        idle(3);

        // Write one cycle after a read request is not forwarded, even with the pipe.
        issue(1'b1, 4'd7, 1'b0, 1'b0, 4'h0, 4'd0, '0, IV, IV, '0);
        issue(1'b0, 4'd0, 1'b0, 1'b1, 4'hF, 4'd7, 32'h12345678, '0, '0, '0);
        idle(3);
        issue(1'b1, 4'd7, 1'b0, 1'b0, 4'h0, 4'd0, '0, 32'h12345678, 32'h12345678, '0);
        idle(3);

        // Different addresses do not interact.
        issue(1'b1, 4'd1, 1'b0, 1'b1, 4'hF, 4'd2, 32'h0BADF00D, IV, IV, '0);
        idle(3);

        // Full-throughput stream on both ports.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'(i), 1'b1, 1'b0, 4'h0, 4'(15 - i), '0,
                  word_after_writes(i), word_after_writes(i), word_after_writes(15 - i));
        end
        idle(3);

        // Reset from READY, then again part-way into the sweep.
        do_reset();
        idle(2);
        rst_n = 1'b1;
        idle(7);
        do_reset();
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'(i), 1'b1, 1'b1, 4'hF, 4'd9, 32'h0, '0, '0, '0);
        end
        idle(2);
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'(i), 1'b1, 1'b0, 4'h0, 4'(i), '0, IV, IV, IV);
        end
        idle(4);

        check("pending expectations", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
